alu_ctrl_seq: RTL and testbench

- Registered, handshaked successor to the combinational ALU-control decoder.
- Accepts {opcode, funct} from decode and produces a registered ALU control word for the execute stage.
- Adds an illegal-instruction flag and a saturating illegal counter.
- Adds multi-cycle sequencing for MULT/DIV, so execute stalls for a parametrised number of cycles.

---
 rtl/alu_ctrl_seq_if.sv | 32 +++
 rtl/alu_ctrl_seq.sv | 152 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
//  alu_ctrl_seq_if
//  Decode-side request and execute-side response bundle for alu_ctrl_seq.
//  Rev 1.0 - initial release
// ============================================================================
interface alu_ctrl_seq_if #(
   parameter int CTL_W = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             out_valid;
   logic             out_ready;
   logic [CTL_W-1:0] alu_ctl;
   logic             illegal;
   logic             busy;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, opcode, funct, out_ready,
      input  in_ready, out_valid, alu_ctl, illegal, busy, illegal_cnt
   );

   modport slave (
      input  in_valid, opcode, funct, out_ready,
      output in_ready, out_valid, alu_ctl, illegal, busy, illegal_cnt
   );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  alu_ctrl_seq
//  Registered, handshaked ALU-control decoder with multi-cycle MULT/DIV stall.
//  Rev 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
   parameter int CTL_W         = 4,
   parameter int MUL_CYCLES    = 4,
   parameter int DIV_CYCLES    = 8,
   parameter int ENABLE_MULDIV = 1,
   parameter int CNT_W         = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_ctrl_seq_if.slave bus
);
   localparam int c_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int c_CYC_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
   localparam logic [c_CYC_W-1:0] c_MUL_LOAD = c_CYC_W'(MUL_CYCLES - 1);
   localparam logic [c_CYC_W-1:0] c_DIV_LOAD = c_CYC_W'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_out_valid;
   logic               r_busy;
   logic [CTL_W-1:0]   r_alu_ctl;
   logic               r_illegal;
   logic [c_CYC_W-1:0] r_cnt;
   logic [CNT_W-1:0]   r_illegal_cnt;

   logic               w_md_en;
   logic [3:0]         w_code;
   logic               w_illegal;
   logic               w_multi;
   logic               w_is_div;
   logic               w_in_ready;
   logic               w_accept;
   logic [c_CYC_W-1:0] w_cnt_load;

   if (ENABLE_MULDIV != 0) begin : g_muldiv_on
      assign w_md_en = 1'b1;
   end else begin : g_muldiv_off
      assign w_md_en = 1'b0;
   end

   always_comb begin
      w_code    = 4'b0000;
      w_illegal = 1'b0;
      w_multi   = 1'b0;
      w_is_div  = 1'b0;
      if (bus.opcode == 6'b000000) begin
         case (bus.funct)
            6'b100000: w_code = 4'b0010;
            6'b100010: w_code = 4'b0110;
            6'b000000: w_code = 4'b0100;
            6'b100100: w_code = 4'b0000;
            6'b100101: w_code = 4'b0101;
            6'b100111: w_code = 4'b1100;
            6'b101010: w_code = 4'b0111;
            6'b001000: w_code = 4'b1111;
            6'b011000: begin
               w_code    = w_md_en ? 4'b1101 : 4'b0000;
               w_illegal = !w_md_en;
               w_multi   = w_md_en;
            end
            6'b011010: begin
               w_code    = w_md_en ? 4'b1110 : 4'b0000;
               w_illegal = !w_md_en;
               w_multi   = w_md_en;
               w_is_div  = 1'b1;
            end
            default:   w_illegal = 1'b1;
         endcase
      end else begin
         case (bus.opcode)
            6'b100011: w_code = 4'b1000;
            6'b101011: w_code = 4'b1001;
            6'b001000: w_code = 4'b0011;
            6'b001100: w_code = 4'b0001;
            6'b000100: w_code = 4'b1010;
            6'b000011: w_code = 4'b1011;
            default:   w_illegal = 1'b1;
         endcase
      end
   end

   // A slot opens when idle, or when the held result is being consumed now.
   assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_cnt_load = w_is_div ? c_DIV_LOAD : c_MUL_LOAD;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_out_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_alu_ctl     <= '0;
         r_illegal     <= 1'b0;
         r_cnt         <= '0;
         r_illegal_cnt <= '0;
      end else if (w_accept) begin
         r_alu_ctl <= CTL_W'(w_code);
         r_illegal <= w_illegal;
         if (w_illegal && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
         end
         if (w_multi) begin
            r_state     <= S_BUSY;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= w_cnt_load;
         end else begin
            r_state     <= S_OUT;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
         end
      end else begin
         case (r_state)
            S_BUSY: begin
               if (r_cnt == '0) begin
                  r_state     <= S_OUT;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.busy        = r_busy;
   assign bus.alu_ctl     = r_alu_ctl;
   assign bus.illegal     = r_illegal;
   assign bus.illegal_cnt = r_illegal_cnt;
endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  tb_alu_ctrl_seq
//  Directed and randomized checks of alu_ctrl_seq against a transaction model.
//  Rev 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   logic       d_v;
   logic [5:0] d_op;
   logic [5:0] d_fn;
   logic       d_ordy;

   // main instance plus two alternate parameterisations
   alu_ctrl_seq_if #(.CTL_W(4), .CNT_W(8)) bus0 ();
   alu_ctrl_seq_if #(.CTL_W(4), .CNT_W(8)) bus1 ();
   alu_ctrl_seq_if #(.CTL_W(4), .CNT_W(8)) bus2 ();

   assign bus0.in_valid  = d_v;
   assign bus0.opcode    = d_op;
   assign bus0.funct     = d_fn;
   assign bus0.out_ready = d_ordy;

   alu_ctrl_seq #(.CTL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8), .ENABLE_MULDIV(1), .CNT_W(8))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
   alu_ctrl_seq #(.CTL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8), .ENABLE_MULDIV(0), .CNT_W(8))
      u_dut_nomd (.clk(clk), .rst_n(rst_n), .bus(bus1));
   alu_ctrl_seq #(.CTL_W(4), .MUL_CYCLES(1), .DIV_CYCLES(8), .ENABLE_MULDIV(1), .CNT_W(8))
      u_dut_m1 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (main instance) ----------------
   int         m_busy_left;
   bit         m_have_out;
   logic [3:0] m_code;
   bit         m_ill;
   int         m_cnt;

   function automatic int ref_code(input logic [5:0] op, input logic [5:0] fn, input bit md);
      if (op == 6'b000000) begin
         case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b000000: return 4;
            6'b100100: return 0;
            6'b100101: return 5;
            6'b100111: return 12;
            6'b101010: return 7;
            6'b001000: return 15;
            6'b011000: return md ? 13 : -1;
            6'b011010: return md ? 14 : -1;
            default:   return -1;
         endcase
      end
      case (op)
         6'b100011: return 8;
         6'b101011: return 9;
         6'b001000: return 3;
         6'b001100: return 1;
         6'b000100: return 10;
         6'b000011: return 11;
         default:   return -1;
      endcase
   endfunction

   function automatic int ref_cycles(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000 && fn == 6'b011000) return 4;
      if (op == 6'b000000 && fn == 6'b011010) return 8;
      return 0;
   endfunction

   function automatic bit exp_rdy();
      return (m_busy_left == 0 && !m_have_out) || (m_have_out && d_ordy);
   endfunction

   task automatic model_reset();
      m_busy_left = 0;
      m_have_out  = 0;
      m_code      = 4'd0;
      m_ill       = 0;
      m_cnt       = 0;
   endtask

   task automatic model_step();
      bit acc;
      int c;
      int n;
      acc = d_v && exp_rdy();
      if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) m_have_out = 1;
      end else begin
         if (m_have_out && d_ordy && !acc) m_have_out = 0;
         if (acc) begin
            c      = ref_code(d_op, d_fn, 1'b1);
            n      = ref_cycles(d_op, d_fn);
            m_ill  = (c < 0);
            m_code = (c < 0) ? 4'd0 : 4'(c);
            if (m_ill && m_cnt < 255) m_cnt++;
            if (n > 0) begin
               m_busy_left = n;
               m_have_out  = 0;
            end else begin
               m_have_out = 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic ordy);
      d_v = v; d_op = op; d_fn = fn; d_ordy = ordy;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %0b want 0", bus0.out_valid); end
      n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset.busy got %0b want 0", bus0.busy); end
      n_cmp++; if (bus0.alu_ctl !== 4'd0) begin n_err++; $display("FAIL reset.alu_ctl got %0h want 0", bus0.alu_ctl); end
      n_cmp++; if (bus0.illegal !== 1'b0) begin n_err++; $display("FAIL reset.illegal got %0b want 0", bus0.illegal); end
      n_cmp++; if (bus0.illegal_cnt !== 8'd0) begin n_err++; $display("FAIL reset.illegal_cnt got %0d want 0", bus0.illegal_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %0b want 1", bus0.in_ready); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[3];
      logic [5:0] fns[3];
      logic [3:0] exp[3];
      ops = '{6'b000000, 6'b100011, 6'b000100};
      fns = '{6'b100000, 6'b000000, 6'b000000};
      exp = '{4'b0010, 4'b1000, 4'b1010};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, ops[i], fns[i], 1'b1);
         else       drive(1'b0, 6'd0, 6'd0, 1'b1);
         #1;
         if (i > 0) begin
            n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b.out_valid[%0d] got %0b want 1", i, bus0.out_valid); end
            n_cmp++; if (bus0.alu_ctl !== exp[i-1]) begin n_err++; $display("FAIL b2b.alu_ctl[%0d] got %0h want %0h", i, bus0.alu_ctl, exp[i-1]); end
            n_cmp++; if (bus0.illegal !== 1'b0) begin n_err++; $display("FAIL b2b.illegal[%0d] got %0b want 0", i, bus0.illegal); end
         end
         tick();
      end
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b.drain got %0b want 0", bus0.out_valid); end
   endtask

   task automatic test_stall();
      drive(1'b1, 6'b101011, 6'd0, 1'b0);
      tick();
      drive(1'b1, 6'b001100, 6'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (bus0.alu_ctl !== 4'b1001 || bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL stall.hold[%0d] got v=%0b ctl=%0h want v=1 ctl=9", i, bus0.out_valid, bus0.alu_ctl); end
         n_cmp++; if (bus0.in_ready !== 1'b0) begin n_err++; $display("FAIL stall.in_ready[%0d] got %0b want 0", i, bus0.in_ready); end
         tick();
      end
      d_ordy = 1'b1;
      #1;
      n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL stall.release got %0b want 1", bus0.in_ready); end
      tick();
      drive(1'b0, 6'd0, 6'd0, 1'b1);
      #1;
      n_cmp++; if (bus0.alu_ctl !== 4'b0001 || bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL stall.andi got v=%0b ctl=%0h want v=1 ctl=1", bus0.out_valid, bus0.alu_ctl); end
      tick();
   endtask

   task automatic run_muldiv(input logic [5:0] fn, input int n, input logic [3:0] code);
      drive(1'b1, 6'b000000, fn, 1'b1);
      tick();
      // an add held valid during the stall must be ignored
      drive(1'b1, 6'b000000, 6'b100000, 1'b1);
      for (int i = 0; i < n; i++) begin
         #1;
         n_cmp++; if (bus0.busy !== 1'b1 || bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL muldiv.busy[%0d] got busy=%0b rdy=%0b v=%0b want 1/0/0", i, bus0.busy, bus0.in_ready, bus0.out_valid); end
         n_cmp++; if (bus0.alu_ctl !== code) begin n_err++; $display("FAIL muldiv.ctl_busy[%0d] got %0h want %0h", i, bus0.alu_ctl, code); end
         tick();
      end
      d_v = 1'b0;
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.busy !== 1'b0 || bus0.alu_ctl !== code) begin n_err++; $display("FAIL muldiv.result got v=%0b busy=%0b ctl=%0h want 1/0/%0h", bus0.out_valid, bus0.busy, bus0.alu_ctl, code); end
      tick();
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL muldiv.drain got %0b want 0", bus0.out_valid); end
   endtask

   task automatic test_muldiv();
      run_muldiv(6'b011000, 4, 4'b1101);
      run_muldiv(6'b011010, 8, 4'b1110);
   endtask

   task automatic test_illegal();
      logic [5:0] op;
      logic [5:0] fn;
      drive(1'b1, 6'b111111, 6'($urandom), 1'b1);
      tick();
      d_v = 1'b0;
      #1;
      n_cmp++; if (bus0.illegal !== 1'b1 || bus0.alu_ctl !== 4'd0 || bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL illegal.first got ill=%0b ctl=%0h v=%0b want 1/0/1", bus0.illegal, bus0.alu_ctl, bus0.out_valid); end
      n_cmp++; if (bus0.illegal_cnt !== 8'd1) begin n_err++; $display("FAIL illegal.cnt1 got %0d want 1", bus0.illegal_cnt); end
      tick();
      for (int i = 0; i < 300; i++) begin
         do begin
            op = 6'($urandom);
            fn = 6'($urandom);
         end while (ref_code(op, fn, 1'b1) >= 0);
         drive(1'b1, op, fn, 1'b1);
         tick();
         if (i == 99) begin
            #1;
            n_cmp++; if (bus0.illegal_cnt !== 8'd101) begin n_err++; $display("FAIL illegal.cnt101 got %0d want 101", bus0.illegal_cnt); end
         end
      end
      drive(1'b0, 6'd0, 6'd0, 1'b1);
      #1;
      n_cmp++; if (bus0.illegal_cnt !== 8'd255) begin n_err++; $display("FAIL illegal.saturate got %0d want 255", bus0.illegal_cnt); end
      tick();
   endtask

   task automatic test_nomd();
      bus1.in_valid = 1'b1; bus1.opcode = 6'b000000; bus1.funct = 6'b011000; bus1.out_ready = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.illegal !== 1'b1 || bus1.alu_ctl !== 4'd0) begin n_err++; $display("FAIL nomd.result got v=%0b ill=%0b ctl=%0h want 1/1/0", bus1.out_valid, bus1.illegal, bus1.alu_ctl); end
      n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL nomd.busy got %0b want 0", bus1.busy); end
      n_cmp++; if (bus1.illegal_cnt !== 8'd1) begin n_err++; $display("FAIL nomd.cnt got %0d want 1", bus1.illegal_cnt); end
      tick();
   endtask

   task automatic test_mul1();
      bus2.in_valid = 1'b1; bus2.opcode = 6'b000000; bus2.funct = 6'b011000; bus2.out_ready = 1'b1;
      tick();
      bus2.funct = 6'b100000;
      #1;
      n_cmp++; if (bus2.busy !== 1'b1 || bus2.in_ready !== 1'b0) begin n_err++; $display("FAIL mul1.busy got busy=%0b rdy=%0b want 1/0", bus2.busy, bus2.in_ready); end
      tick();
      #1;
      n_cmp++; if (bus2.out_valid !== 1'b1 || bus2.alu_ctl !== 4'b1101 || bus2.busy !== 1'b0) begin n_err++; $display("FAIL mul1.mult got v=%0b ctl=%0h busy=%0b want 1/d/0", bus2.out_valid, bus2.alu_ctl, bus2.busy); end
      tick();
      bus2.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus2.out_valid !== 1'b1 || bus2.alu_ctl !== 4'b0010) begin n_err++; $display("FAIL mul1.add got v=%0b ctl=%0h want 1/2", bus2.out_valid, bus2.alu_ctl); end
      tick();
      #1;
      n_cmp++; if (bus2.out_valid !== 1'b0) begin n_err++; $display("FAIL mul1.drain got %0b want 0", bus2.out_valid); end
   endtask

   task automatic test_reset_mid_busy();
      int seen;
      drive(1'b1, 6'b000000, 6'b011010, 1'b1);
      tick();
      d_v = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.alu_ctl !== 4'd0 || bus0.illegal !== 1'b0) begin n_err++; $display("FAIL rstbusy.outputs got v=%0b busy=%0b ctl=%0h ill=%0b want all 0", bus0.out_valid, bus0.busy, bus0.alu_ctl, bus0.illegal); end
      n_cmp++; if (bus0.illegal_cnt !== 8'd0) begin n_err++; $display("FAIL rstbusy.cnt got %0d want 0", bus0.illegal_cnt); end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0) seen++;
         tick();
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstbusy.no_emit got %0d active cycles want 0", seen); end
      drive(1'b1, 6'b000000, 6'b100000, 1'b1);
      tick();
      d_v = 1'b0;
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b1 || bus0.alu_ctl !== 4'b0010) begin n_err++; $display("FAIL rstbusy.add got v=%0b ctl=%0h want 1/2", bus0.out_valid, bus0.alu_ctl); end
      tick();
   endtask

   function automatic logic [11:0] pick_op();
      logic [5:0] rfn[10];
      logic [5:0] iop[6];
      rfn = '{6'b100000, 6'b100010, 6'b000000, 6'b100100, 6'b100101,
              6'b100111, 6'b101010, 6'b001000, 6'b011000, 6'b011010};
      iop = '{6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b000100, 6'b000011};
      case ($urandom_range(0, 3))
         0:       return {6'b000000, rfn[$urandom_range(0, 9)]};
         1:       return {iop[$urandom_range(0, 5)], 6'($urandom)};
         2:       return {6'b000000, rfn[$urandom_range(0, 7)]};
         default: return 12'($urandom);
      endcase
   endfunction

   task automatic test_random();
      logic [11:0] p;
      for (int i = 0; i < 400; i++) begin
         p = pick_op();
         drive(1'($urandom_range(0, 3) != 0), p[11:6], p[5:0], 1'($urandom_range(0, 2) != 0));
         #1;
         n_cmp++; if (bus0.in_ready !== exp_rdy()) begin n_err++; $display("FAIL rand.in_ready[%0d] got %0b want %0b", i, bus0.in_ready, exp_rdy()); end
         n_cmp++; if (bus0.out_valid !== m_have_out) begin n_err++; $display("FAIL rand.out_valid[%0d] got %0b want %0b", i, bus0.out_valid, m_have_out); end
         n_cmp++; if (bus0.busy !== (m_busy_left > 0)) begin n_err++; $display("FAIL rand.busy[%0d] got %0b want %0b", i, bus0.busy, (m_busy_left > 0)); end
         n_cmp++; if (bus0.illegal_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rand.cnt[%0d] got %0d want %0d", i, bus0.illegal_cnt, m_cnt); end
         if (m_have_out || m_busy_left > 0) begin
            n_cmp++; if (bus0.alu_ctl !== m_code) begin n_err++; $display("FAIL rand.alu_ctl[%0d] got %0h want %0h", i, bus0.alu_ctl, m_code); end
         end
         if (m_have_out) begin
            n_cmp++; if (bus0.illegal !== m_ill) begin n_err++; $display("FAIL rand.illegal[%0d] got %0b want %0b", i, bus0.illegal, m_ill); end
         end
         tick();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 6'd0, 6'd0, 1'b0);
      bus1.in_valid = 1'b0; bus1.opcode = 6'd0; bus1.funct = 6'd0; bus1.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.opcode = 6'd0; bus2.funct = 6'd0; bus2.out_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      test_back_to_back();
      test_stall();
      test_muldiv();
      test_illegal();
      test_nomd();
      test_mul1();
      test_reset_mid_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
